// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register indices, pipeline controller states and stage-control helpers.
package cpu_types_pkg;

   localparam int unsigned REG_W = 5;

   typedef logic [REG_W-1:0] regbits_t;

   // Pipeline controller FSM states
   typedef enum logic [1:0] {
      PC_RUN,
      PC_DWAIT,
      PC_HALT
   } pctrl_state_t;

   // Which priority rule governs the current cycle
   typedef enum logic [2:0] {
      RULE_HALT,
      RULE_DWAIT,
      RULE_MHALT,
      RULE_REDIRECT,
      RULE_LOADUSE,
      RULE_NORMAL
   } pctrl_rule_t;

   // Per-stage register control pair
   typedef struct packed {
      logic en;
      logic flush;
   } stage_ctrl_t;

   localparam stage_ctrl_t STAGE_ADVANCE = '{en: 1'b1, flush: 1'b0};
   localparam stage_ctrl_t STAGE_BUBBLE  = '{en: 1'b1, flush: 1'b1};
   localparam stage_ctrl_t STAGE_HOLD    = '{en: 1'b0, flush: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the ID instruction.
module load_use_detect
   import cpu_types_pkg::*;
(
   input  logic           ex_dREN,
   input  logic [REG_W-1:0] ex_wsel,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic           id_uses_rt,
   output logic           hazard
);

   logic rs_match;
   logic rt_match;

   // Register 0 is hardwired, so a load targeting it never creates a dependency
   always_comb begin
      rs_match = (ex_wsel == id_rs);
      rt_match = id_uses_rt & (ex_wsel == id_rt);
      hazard   = ex_dREN & (ex_wsel != '0) & (rs_match | rt_match);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
module pipeline_ctrl
   import cpu_types_pkg::*;
#(
   parameter int unsigned STALL_CNT_W = 32
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   ihit,
   input  logic                   dhit,
   input  logic                   mem_dREN,
   input  logic                   mem_dWEN,
   input  logic                   mem_redirect,
   input  logic                   mem_halt,
   input  logic                   ex_dREN,
   input  logic [REG_W-1:0]       ex_wsel,
   input  logic [REG_W-1:0]       id_rs,
   input  logic [REG_W-1:0]       id_rt,
   input  logic                   id_uses_rt,
   output logic                   pc_en,
   output logic                   ifid_en,
   output logic                   idex_en,
   output logic                   exmem_en,
   output logic                   memwb_en,
   output logic                   ifid_flush,
   output logic                   idex_flush,
   output logic                   exmem_flush,
   output logic                   memwb_flush,
   output logic                   halt,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   pctrl_state_t           state_q, state_d;
   logic                   fetch_done_q, fetch_done_d;
   logic                   halt_q, halt_d;
   logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

   pctrl_rule_t rule;
   logic        dwait;
   logic        fetch_ok;
   logic        load_use;
   stage_ctrl_t ifid_c, idex_c, exmem_c, memwb_c;

   load_use_detect u_load_use_detect (
      .ex_dREN    (ex_dREN),
      .ex_wsel    (ex_wsel),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .hazard     (load_use)
   );

   // Pick the highest-priority rule that applies this cycle
   always_comb begin
      dwait    = (mem_dREN | mem_dWEN) & ~dhit;
      fetch_ok = ihit | fetch_done_q;
      rule     = RULE_NORMAL;
      if (state_q == PC_HALT) begin
         rule = RULE_HALT;
      end else if (dwait) begin
         rule = RULE_DWAIT;
      end else if (mem_halt) begin
         rule = RULE_MHALT;
      end else if (mem_redirect) begin
         rule = RULE_REDIRECT;
      end else if (load_use) begin
         rule = RULE_LOADUSE;
      end
   end

   // State register: FSM, fetch-done latch, halt flag, stall counter
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q      <= PC_RUN;
         fetch_done_q <= 1'b0;
         halt_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         fetch_done_q <= fetch_done_d;
         halt_q       <= halt_d;
         cnt_q        <= cnt_d;
      end
   end

   // Next-state logic; DWAIT leaves on dhit and that cycle is handled by the lower rules
   always_comb begin
      state_d = state_q;
      unique case (rule)
         RULE_HALT:  state_d = PC_HALT;
         RULE_DWAIT: state_d = PC_DWAIT;
         RULE_MHALT: state_d = PC_HALT;
         default:    state_d = PC_RUN;
      endcase
      halt_d = (state_d == PC_HALT);
   end

   // Stage control priority mux; reset bubbles every stage
   always_comb begin
      pc_en   = 1'b0;
      ifid_c  = STALL_ADVANCE_DEFAULT();
      idex_c  = STAGE_ADVANCE;
      exmem_c = STAGE_ADVANCE;
      memwb_c = STAGE_ADVANCE;
      if (!nRST) begin
         ifid_c  = STAGE_BUBBLE;
         idex_c  = STAGE_BUBBLE;
         exmem_c = STAGE_BUBBLE;
         memwb_c = STAGE_BUBBLE;
      end else begin
         unique case (rule)
            RULE_HALT: begin
               ifid_c  = STAGE_HOLD;
               idex_c  = STAGE_HOLD;
               exmem_c = STAGE_HOLD;
               memwb_c = STAGE_HOLD;
            end
            RULE_DWAIT: begin
               ifid_c  = STAGE_HOLD;
               idex_c  = STAGE_HOLD;
               exmem_c = STAGE_HOLD;
               memwb_c = STAGE_BUBBLE;
            end
            RULE_MHALT: begin
               ifid_c  = STAGE_BUBBLE;
               idex_c  = STAGE_BUBBLE;
               exmem_c = STAGE_BUBBLE;
            end
            RULE_REDIRECT: begin
               pc_en   = 1'b1;
               ifid_c  = STAGE_BUBBLE;
               idex_c  = STAGE_BUBBLE;
               exmem_c = STAGE_BUBBLE;
            end
            RULE_LOADUSE: begin
               ifid_c  = STAGE_HOLD;
               idex_c  = STAGE_BUBBLE;
            end
            default: begin
               pc_en  = fetch_ok;
               ifid_c = fetch_ok ? STAGE_ADVANCE : STAGE_BUBBLE;
            end
         endcase
      end
   end

   // Fetch-done latch remembers an instruction that arrived while the PC was held
   always_comb begin
      fetch_done_d = fetch_done_q;
      if (pc_en || mem_redirect) begin
         fetch_done_d = 1'b0;
      end else if (ihit && (rule == RULE_DWAIT || rule == RULE_LOADUSE)) begin
         fetch_done_d = 1'b1;
      end
   end

   // Saturating count of PC-stall cycles outside HALT
   always_comb begin
      cnt_d = cnt_q;
      if (!pc_en && (state_q != PC_HALT) && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Unpack stage controls onto the ports
   always_comb begin
      ifid_en     = ifid_c.en;
      ifid_flush  = ifid_c.flush;
      idex_en     = idex_c.en;
      idex_flush  = idex_c.flush;
      exmem_en    = exmem_c.en;
      exmem_flush = exmem_c.flush;
      memwb_en    = memwb_c.en;
      memwb_flush = memwb_c.flush;
      halt        = halt_q;
      stall_cnt   = cnt_q;
   end

   function automatic stage_ctrl_t STALL_ADVANCE_DEFAULT();
      return STAGE_ADVANCE;
   endfunction

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver queues hand-computed expectations, monitor checks.
module tb_pipeline_ctrl;

   logic       CLK;
   logic       nRST;
   logic       ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, mem_halt;
   logic       ex_dREN, id_uses_rt;
   logic [4:0] ex_wsel, id_rs, id_rt;

   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
   logic [31:0] stall_cnt;

   logic        pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
   logic        ifid_flush4, idex_flush4, exmem_flush4, memwb_flush4, halt4;
   logic [3:0]  stall_cnt4;

   typedef struct {
      int          id;
      logic        pc;
      logic [3:0]  en;
      logic [3:0]  fl;
      logic        hlt;
      logic [31:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   step_id = 0;

   pipeline_ctrl #(.STALL_CNT_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
      .mem_dWEN(mem_dWEN), .mem_redirect(mem_redirect), .mem_halt(mem_halt),
      .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .halt(halt), .stall_cnt(stall_cnt)
   );

   pipeline_ctrl #(.STALL_CNT_W(4)) dut4 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
      .mem_dWEN(mem_dWEN), .mem_redirect(mem_redirect), .mem_halt(mem_halt),
      .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4),
      .exmem_en(exmem_en4), .memwb_en(memwb_en4), .ifid_flush(ifid_flush4),
      .idex_flush(idex_flush4), .exmem_flush(exmem_flush4), .memwb_flush(memwb_flush4),
      .halt(halt4), .stall_cnt(stall_cnt4)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // One cycle of stimulus plus its expected response
   task automatic step(input logic rn, input logic ih, input logic dh, input logic dr,
                       input logic dw, input logic rd, input logic mh, input logic xr,
                       input logic [4:0] xw, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic epc, input logic [3:0] een,
                       input logic [3:0] efl, input logic eh, input int ecnt);
      exp_t e;
      @(posedge CLK);
      #1;
      nRST = rn; ihit = ih; dhit = dh; mem_dREN = dr; mem_dWEN = dw;
      mem_redirect = rd; mem_halt = mh; ex_dREN = xr; ex_wsel = xw;
      id_rs = rs; id_rt = rt; id_uses_rt = ur;
      step_id++;
      e.id   = step_id;
      e.pc   = epc;
      e.en   = een;
      e.fl   = efl;
      e.hlt  = eh;
      e.cnt  = 32'(ecnt);
      e.cnt4 = (ecnt > 15) ? 4'hF : 4'(ecnt);
      sb.push_back(e);
   endtask

   // Monitor: outputs are combinational, so every cycle presents a response
   initial begin
      exp_t e;
      logic [3:0] en, fl;
      forever begin
         @(negedge CLK);
         if (sb.size() > 0) begin
            e  = sb.pop_front();
            en = {ifid_en, idex_en, exmem_en, memwb_en};
            fl = {ifid_flush, idex_flush, exmem_flush, memwb_flush};
            n_tests++;
            if (pc_en !== e.pc || en !== e.en || fl !== e.fl || halt !== e.hlt ||
                stall_cnt !== e.cnt || stall_cnt4 !== e.cnt4) begin
               n_fail++;
               $display("FAIL step%0d: got pc=%b en=%b fl=%b halt=%b cnt=%0d cnt4=%0d, want pc=%b en=%b fl=%b halt=%b cnt=%0d cnt4=%0d",
                        e.id, pc_en, en, fl, halt, stall_cnt, stall_cnt4,
                        e.pc, e.en, e.fl, e.hlt, e.cnt, e.cnt4);
            end
         end
      end
   end

   initial begin
      int guard;
      nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
      mem_redirect = 1'b0; mem_halt = 1'b0; ex_dREN = 1'b0; ex_wsel = '0;
      id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
      repeat (2) @(posedge CLK);

      //   rn ih dh dr dw rd mh xr xw  rs  rt ur   pc en       fl       h cnt
      // Reset bubbles every stage
      step(0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   0, 4'b1111, 4'b1111, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   0, 4'b1111, 4'b1111, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   1, 4'b1111, 4'b0000, 0, 0);
      // Load-use on rs: one bubble, fetch_done covers the next cycle
      step(1, 1, 0, 0, 0, 0, 0, 1, 8,  8,  0, 0,   0, 4'b0111, 4'b0100, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   1, 4'b1111, 4'b0000, 0, 1);
      // Load to r0 never stalls
      step(1, 1, 0, 0, 0, 0, 0, 1, 0,  0,  0, 0,   1, 4'b1111, 4'b0000, 0, 1);
      // Data wait three cycles, ihit in the middle one
      step(1, 0, 0, 1, 0, 0, 0, 0, 0,  0,  0, 0,   0, 4'b0001, 4'b0001, 0, 1);
      step(1, 1, 0, 1, 0, 0, 0, 0, 0,  0,  0, 0,   0, 4'b0001, 4'b0001, 0, 2);
      step(1, 0, 0, 1, 0, 0, 0, 0, 0,  0,  0, 0,   0, 4'b0001, 4'b0001, 0, 3);
      step(1, 0, 1, 1, 0, 0, 0, 0, 0,  0,  0, 0,   1, 4'b1111, 4'b0000, 0, 4);
      // Redirect beats a simultaneous load-use
      step(1, 1, 0, 0, 0, 1, 0, 1, 9,  9,  0, 0,   1, 4'b1111, 4'b1110, 0, 4);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   1, 4'b1111, 4'b0000, 0, 4);
      // Store wait beats redirect; redirect taken when dhit arrives
      step(1, 0, 0, 0, 1, 1, 0, 0, 0,  0,  0, 0,   0, 4'b0001, 4'b0001, 0, 4);
      step(1, 0, 1, 0, 1, 1, 0, 0, 0,  0,  0, 0,   1, 4'b1111, 4'b1110, 0, 5);
      // Load-use on rt only when rt is read
      step(1, 1, 0, 0, 0, 0, 0, 1, 3,  1,  3, 1,   0, 4'b0111, 4'b0100, 0, 5);
      step(1, 1, 0, 0, 0, 0, 0, 1, 3,  1,  3, 0,   1, 4'b1111, 4'b0000, 0, 6);
      // Fetch miss bubbles IF/ID
      step(1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   0, 4'b1111, 4'b1000, 0, 6);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   1, 4'b1111, 4'b0000, 0, 7);
      // HALT: flush cycle, then frozen
      step(1, 1, 0, 0, 0, 0, 1, 0, 0,  0,  0, 0,   0, 4'b1111, 4'b1110, 0, 7);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   0, 4'b0000, 4'b0000, 1, 8);
      step(1, 0, 0, 1, 0, 1, 0, 1, 4,  4,  0, 0,   0, 4'b0000, 4'b0000, 1, 8);
      // Reset out of HALT
      step(0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   0, 4'b1111, 4'b1111, 1, 8);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   0, 4'b1111, 4'b1111, 0, 0);
      // Saturation of the 4-bit counter
      for (int i = 0; i <= 20; i++) begin
         step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 4'b1111, 4'b1000, 0, i);
      end

      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
         @(posedge CLK);
         guard++;
      end
      @(posedge CLK);
      if (sb.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending checks, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. Each cycle it drives the enable and flush pair of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It arbitrates instruction-fetch waits, data-memory waits, load-use hazards, taken branches/jumps and HALT. It keeps a small FSM, a fetch-done latch and a stall-cycle counter.

## Interface
Parameters:
- STALL_CNT_W, 32, width of the saturating stall-cycle counter

Ports:
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  synchronous active-low reset
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- mem_dREN  in  1  load in MEM stage
- mem_dWEN  in  1  store in MEM stage
- mem_redirect  in  1  branch taken or jump resolved in MEM; PC loads target
- mem_halt  in  1  HALT instruction in MEM stage
- ex_dREN  in  1  load in EX stage
- ex_wsel  in  5  destination register of EX instruction
- id_rs  in  5  rs of ID instruction
- id_rt  in  5  rt of ID instruction
- id_uses_rt  in  1  ID instruction reads rt
- pc_en  out  1  PC loads next value
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register loads
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  stage register loads a bubble (meaningful only when matching en=1)
- halt  out  1  processor halted, registered
- stall_cnt  out  STALL_CNT_W  cycles with pc_en=0 outside HALT

## Operation
- FSM states are RUN, DWAIT and HALT. Reset state is RUN.
- Stage semantics: en=1,flush=0 advances; en=1,flush=1 loads a bubble; en=0 holds.
- fetch_ok = ihit | fetch_done.
- Conditions are evaluated in priority order; the first match wins.
  1. HALT state: all en=0, all flush=0, halt=1. Exit only through reset.
  2. dwait = (mem_dREN|mem_dWEN) & ~dhit. Action: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_en=1, memwb_flush=1. Next state is DWAIT. DWAIT returns to RUN on the cycle dhit is seen, and that cycle follows the lower-priority rules.
  3. mem_halt: pc_en=0; ifid, idex, exmem load bubbles; memwb advances. Next state is HALT.
  4. mem_redirect: pc_en=1; ifid, idex, exmem load bubbles; memwb advances. fetch_done is cleared.
  5. Load-use hazard, defined as ex_dREN & ex_wsel≠0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)): pc_en=0, ifid_en=0, idex bubble, exmem and memwb advance.
  6. Otherwise all back-end stages advance.
     - If fetch_ok: pc_en=1, ifid advances, fetch_done cleared.
     - Else: pc_en=0, ifid bubble.
- fetch_done latch:
  - Set when ihit=1 in a cycle where pc_en=0 because of rule 2 or 5.
  - Cleared when pc_en=1 or mem_redirect.
  - Prevents re-waiting for an instruction that has already been fetched.
- stall_cnt increments when pc_en=0 and the state is not HALT, including the mem_halt cycle. It saturates at all-ones.
- Register 0 never causes a hazard.

## Timing
- All enables and flushes are combinational from inputs and state, valid in the same cycle, and sampled by the stage registers at the same edge.
- halt is registered: it asserts on the first edge after the rule-3 cycle.
- Load-use hazard costs exactly one bubble. Redirect costs three bubbles.
- Simultaneous events:
  - dwait with mem_redirect or mem_halt: dwait wins. Redirect/halt is acted on in the cycle dhit arrives, since MEM is held.
  - mem_redirect with load-use: redirect wins.
  - ihit during dwait: latched into fetch_done, with no PC update.
- Reset is sampled at the edge with nRST=0.
  - Registered state: state=RUN, fetch_done=0, stall_cnt=0, halt=0.
  - While nRST=0 the outputs are all en=1, all flush=1, pc_en=0, so every stage is bubbled.
- Reset mid-DWAIT or in HALT returns to RUN on the next edge.

## Structure
- cpu_types_pkg gains typedef enum logic [1:0] pctrl_state_t {PC_RUN, PC_DWAIT, PC_HALT}. Register-index fields reuse the existing regbits_t.
- One combinational sub-module, load_use_detect, takes (ex_dREN, ex_wsel, id_rs, id_rt, id_uses_rt) and produces the hazard signal.
- FSM, fetch_done, counter and priority mux live in pipeline_ctrl.

## Test plan
- Reset with nRST=0 for 2 cycles:
  - halt=0, stall_cnt=0, pc_en=0, all flush=1.
  - After release with ihit=1: pc_en=1, all en=1, all flush=0.
- Load-use with ex_dREN=1, ex_wsel=5'd8, id_rs=8, ihit=1:
  - One cycle of pc_en=0, ifid_en=0, idex_flush=1.
  - stall_cnt +1.
  - With ex_wsel=0 instead: no stall.
- mem_dREN=1 and dhit=0 for 3 cycles, with ihit pulse in cycle 2:
  - Front three stages hold and memwb bubbles for 3 cycles.
  - When dhit=1, pc_en=1 without a new ihit (fetch_done path).
  - stall_cnt=3.
- mem_redirect with a simultaneous load-use hazard:
  - pc_en=1; ifid, idex, exmem flush; memwb advances.
  - The next cycle is normal.
- mem_halt=1: same-cycle pc_en=0 and three flushes; halt=1 after the edge; all en=0 thereafter; stall_cnt frozen.
- Saturation: with STALL_CNT_W=4, hold ihit=0 for 20 cycles; stall_cnt stops at 4'hF.
